// File: rtl/pf_lanectrl_pause_gen_if.sv
// Handshake and status bundle between a lane-update requester and the
// pause sequencer. The requester owns UPDATE_REQ; everything else is
// produced by the sequencer.
interface pf_lanectrl_pause_gen_if;
  logic       UPDATE_REQ;
  logic       HS_IO_CLK_PAUSE;
  logic       LANE_UPDATE;
  logic       BUSY;
  logic       UPDATE_DONE;
  logic       PENDING;
  logic [7:0] UPDATE_COUNT;

  modport master (
    output UPDATE_REQ,
    input  HS_IO_CLK_PAUSE,
    input  LANE_UPDATE,
    input  BUSY,
    input  UPDATE_DONE,
    input  PENDING,
    input  UPDATE_COUNT
  );

  modport slave (
    input  UPDATE_REQ,
    output HS_IO_CLK_PAUSE,
    output LANE_UPDATE,
    output BUSY,
    output UPDATE_DONE,
    output PENDING,
    output UPDATE_COUNT
  );
endinterface

// File: rtl/pf_lanectrl_pause_gen.sv
// Lane-controller clock-pause sequencer. Raises HS_IO_CLK_PAUSE for
// PRE_CYCLES before a single LANE_UPDATE strobe and POST_CYCLES after it,
// waits GAP_CYCLES with the pause released, then pulses UPDATE_DONE.
// A request that arrives while a sequence runs is held (one deep) and
// launched once the sequencer is back in IDLE. All outputs are registered
// straight from the next-state decode so they never glitch.
module pf_lanectrl_pause_gen #(
  parameter int unsigned PRE_CYCLES  = 4,
  parameter int unsigned POST_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 2,
  parameter int unsigned CNT_WIDTH   = 4
) (
  input  logic                  CLK,
  input  logic                  RESET,
  pf_lanectrl_pause_gen_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_UPD,
    ST_POST,
    ST_GAP,
    ST_DONE
  } state_t;

  // Counter reload values: a state of length N counts N-1 down to 0.
  localparam logic [CNT_WIDTH-1:0] PRE_LOAD  = CNT_WIDTH'(PRE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] POST_LOAD = CNT_WIDTH'(POST_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] GAP_LOAD  = CNT_WIDTH'(GAP_CYCLES - 1);

  state_t               state;
  state_t               state_next;
  logic [CNT_WIDTH-1:0] phase_cnt;
  logic [CNT_WIDTH-1:0] cnt_next;
  logic                 pending;
  logic                 pending_next;

  // Next-state, phase counter and pending-request capture.
  always_comb begin
    state_next   = state;
    cnt_next     = phase_cnt;
    pending_next = pending;
    case (state)
      ST_IDLE: begin
        if (bus.UPDATE_REQ || pending) begin
          state_next   = ST_PRE;
          cnt_next     = PRE_LOAD;
          pending_next = 1'b0;
        end
      end
      ST_PRE: begin
        if (phase_cnt == '0) begin
          state_next = ST_UPD;
          cnt_next   = '0;
        end else begin
          cnt_next = phase_cnt - 1'b1;
        end
      end
      ST_UPD: begin
        state_next = ST_POST;
        cnt_next   = POST_LOAD;
      end
      ST_POST: begin
        if (phase_cnt == '0) begin
          state_next = ST_GAP;
          cnt_next   = GAP_LOAD;
        end else begin
          cnt_next = phase_cnt - 1'b1;
        end
      end
      ST_GAP: begin
        if (phase_cnt == '0) begin
          state_next = ST_DONE;
          cnt_next   = '0;
        end else begin
          cnt_next = phase_cnt - 1'b1;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
    // Requests seen outside IDLE merge into a single queued request.
    if ((state != ST_IDLE) && bus.UPDATE_REQ) begin
      pending_next = 1'b1;
    end
  end

  // State register plus outputs registered from the next-state decode.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state               <= ST_IDLE;
      phase_cnt           <= '0;
      pending             <= 1'b0;
      bus.HS_IO_CLK_PAUSE <= 1'b0;
      bus.LANE_UPDATE     <= 1'b0;
      bus.BUSY            <= 1'b0;
      bus.UPDATE_DONE     <= 1'b0;
      bus.PENDING         <= 1'b0;
      bus.UPDATE_COUNT    <= 8'd0;
    end else begin
      state               <= state_next;
      phase_cnt           <= cnt_next;
      pending             <= pending_next;
      bus.HS_IO_CLK_PAUSE <= (state_next == ST_PRE) || (state_next == ST_UPD) ||
                             (state_next == ST_POST);
      bus.LANE_UPDATE     <= (state_next == ST_UPD);
      bus.BUSY            <= (state_next != ST_IDLE);
      bus.UPDATE_DONE     <= (state_next == ST_DONE);
      bus.PENDING         <= pending_next;
      if (state_next == ST_DONE) begin
        bus.UPDATE_COUNT <= bus.UPDATE_COUNT + 8'd1;
      end
    end
  end

endmodule

// File: doc/pf_lanectrl_pause_gen.md
# pf_lanectrl_pause_gen

Sequencer that generates the lane-controller clock-pause window around a single-cycle lane update strobe (delay-line move or divider reload). It sits directly upstream of the lane-controller pause synchronizer: its HS_IO_CLK_PAUSE output drives that synchronizer, and its LANE_UPDATE strobe goes to the lane controller. Requests arrive on a request/done handshake with one-deep pending capture. The block also keeps a wrapping count of completed updates.

## Interface

Parameters:
- PRE_CYCLES, default 4: number of cycles HS_IO_CLK_PAUSE is high before LANE_UPDATE. Legal range 1..2^CNT_WIDTH.
- POST_CYCLES, default 4: number of cycles HS_IO_CLK_PAUSE stays high after the LANE_UPDATE cycle. Legal range 1..2^CNT_WIDTH.
- GAP_CYCLES, default 2: number of cycles, with pause low, before UPDATE_DONE. Legal range 1..2^CNT_WIDTH.
- CNT_WIDTH, default 4: width of the internal phase counter.

Ports:
- CLK  in  1  sole clock.
- RESET  in  1  reset, synchronous to CLK, active-high.
- UPDATE_REQ  in  1  request; sampled every cycle.
- HS_IO_CLK_PAUSE  out  1  pause window, registered.
- LANE_UPDATE  out  1  one-cycle update strobe, registered.
- BUSY  out  1  high while a sequence is in progress.
- UPDATE_DONE  out  1  one-cycle completion pulse.
- PENDING  out  1  a request is captured and waiting.
- UPDATE_COUNT  out  8  number of completed sequences; wraps.

## Operation

- States and transitions:
  - IDLE -> PRE when UPDATE_REQ or PENDING is sampled high.
  - PRE (PRE_CYCLES cycles) -> UPD.
  - UPD (1 cycle) -> POST.
  - POST (POST_CYCLES cycles) -> GAP.
  - GAP (GAP_CYCLES cycles) -> DONE.
  - DONE (1 cycle) -> IDLE.
- Output decode, all registered from next-state:
  - HS_IO_CLK_PAUSE = 1 in PRE, UPD and POST.
  - LANE_UPDATE = 1 in UPD only.
  - UPDATE_DONE = 1 in DONE only.
  - BUSY = 1 in every state except IDLE.
- Phase counter:
  - Loaded with N-1 on entry to each multi-cycle state, where N is that state's length.
  - Decrements each cycle; the state exits when the counter is 0.
  - Does not wrap; it is reloaded on every state entry.
- Request handling:
  - UPDATE_REQ high in IDLE starts a sequence, and PENDING is cleared.
  - UPDATE_REQ high in any non-IDLE state sets PENDING. Further requests are merged: at most one is queued.
  - On the return to IDLE, PENDING high starts the next sequence in the following cycle. The exit from IDLE is the same as for a fresh request.
  - UPDATE_REQ held high continuously gives back-to-back sequences with exactly one IDLE cycle between them.
- UPDATE_COUNT increments by 1 in the DONE cycle and wraps 255 -> 0.
- Reset values, applied in the cycle after RESET is sampled high:
  - All outputs are 0.
  - State is IDLE, the counter is 0 and PENDING is 0.
  - This also applies mid-sequence: pause drops with no LANE_UPDATE or UPDATE_DONE emitted, and the count is not incremented.
  - UPDATE_REQ is ignored while RESET is high.

## Timing

Cycle 0 is the cycle in which the request is sampled in IDLE. P = PRE_CYCLES, Q = POST_CYCLES, G = GAP_CYCLES.
- HS_IO_CLK_PAUSE is high in cycles 1 .. P+Q+1, a width of P+Q+1.
- LANE_UPDATE is high in cycle P+1.
- HS_IO_CLK_PAUSE is low from cycle P+Q+2.
- The GAP state spans cycles P+Q+2 .. P+Q+G+1.
- UPDATE_DONE is high in cycle P+Q+G+2. BUSY is high in cycles 1 .. P+Q+G+2.
- IDLE is reached in cycle P+Q+G+3. The earliest following sequence raises pause in cycle P+Q+G+4.
- Defaults (P=4, Q=4, G=2):
  - pause is high in cycles 1–9;
  - update occurs in cycle 5;
  - done occurs in cycle 12;
  - the next pause starts in cycle 14.
- A request in the DONE cycle is captured into PENDING. A request in the IDLE cycle starts a sequence directly. Both give the same start cycle.
- LANE_UPDATE never coincides with a pause edge: there are at least P cycles of pause before it and Q cycles after it.

## Test plan

- Defaults, 1-cycle UPDATE_REQ at cycle 0 -> pause high in cycles 1–9 (9 cycles), LANE_UPDATE only in cycle 5, UPDATE_DONE only in cycle 12, BUSY high in cycles 1–12, UPDATE_COUNT=1.
- Requests at cycles 3 and 7 of a running sequence -> PENDING=1 from cycle 4; exactly one extra sequence, with pause rising in cycle 14; UPDATE_COUNT=2 after cycle 25.
- UPDATE_REQ held high for 40 cycles -> sequences start at cycles 0, 13 and 26; IDLE lasts exactly one cycle between sequences; UPDATE_COUNT=3.
- RESET asserted at cycle 6, mid-POST -> all outputs 0 from cycle 7; no UPDATE_DONE; UPDATE_COUNT unchanged; a new request after reset gives the full nominal timing.
- P=1, Q=1, G=1 -> pause high in cycles 1–3, update in cycle 2, done in cycle 5.
- 256 sequences -> UPDATE_COUNT wraps to 0.
